// File: rtl/move_decoder_if.sv
// Request/move handshake bundle for move_decoder.
// The slave side is the decoder; the master side is the input path plus the game core.
interface move_decoder_if #(
    parameter int CELLS = 9,
    parameter int IDX_W = 4
);
    logic [IDX_W-1:0] cell_idx;
    logic             idx_valid;
    logic [CELLS-1:0] move;
    logic             move_valid;
    logic             move_ready;

    modport master (
        output cell_idx,
        output idx_valid,
        output move_ready,
        input  move,
        input  move_valid
    );

    modport slave (
        input  cell_idx,
        input  idx_valid,
        input  move_ready,
        output move,
        output move_valid
    );
endinterface

// File: rtl/move_decoder.sv
// Cell index to one-hot move decoder with legality check and X/O turn tracking.
// Optional one-level undo is enabled by defining MOVE_UNDO_EN.
module move_decoder #(
    parameter int CELLS = 9,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    move_decoder_if.slave    bus,
    input  logic             clear_board,
`ifdef MOVE_UNDO_EN
    input  logic             undo,
`endif
    output logic             player,
    output logic [CELLS-1:0] x_board,
    output logic [CELLS-1:0] o_board,
    output logic             reject,
    output logic             board_full
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        ISSUE,
        FULL
    } state_t;

    localparam logic [CELLS-1:0] ALL = {CELLS{1'b1}};
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(CELLS - 1);

    state_t           state, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CELLS-1:0] move_q, move_d;
    logic             mv_q, mv_d;
    logic             player_d;
    logic [CELLS-1:0] x_d, o_d;
    logic             reject_d;
    logic [CELLS-1:0] onehot;
    logic             legal;

`ifdef MOVE_UNDO_EN
    logic [CELLS-1:0] last_q, last_d;
    logic             last_vld, last_vld_d;
    logic             do_undo;
`endif

    // Out-of-range indices shift to zero, so only the range check is needed for them.
    assign onehot = CELLS'(1) << idx_q;
    assign legal  = (idx_q <= MAX_IDX) && ((onehot & (x_board | o_board)) == '0);

    assign bus.move       = move_q;
    assign bus.move_valid = mv_q;
    assign board_full     = (state == FULL);

`ifdef MOVE_UNDO_EN
    assign do_undo = undo && last_vld && ((state == IDLE) || (state == FULL));
`endif

    // Next-state and datapath updates; clear_board acts like reset.
    always_comb begin
        state_d  = state;
        idx_d    = idx_q;
        move_d   = move_q;
        mv_d     = mv_q;
        player_d = player;
        x_d      = x_board;
        o_d      = o_board;
        reject_d = 1'b0;
`ifdef MOVE_UNDO_EN
        last_d     = last_q;
        last_vld_d = last_vld;
`endif
        if (clear_board) begin
            state_d  = IDLE;
            idx_d    = '0;
            move_d   = '0;
            mv_d     = 1'b0;
            player_d = 1'b0;
            x_d      = '0;
            o_d      = '0;
`ifdef MOVE_UNDO_EN
            last_d     = '0;
            last_vld_d = 1'b0;
`endif
        end
`ifdef MOVE_UNDO_EN
        else if (do_undo) begin
            // player already points at the side after the last move.
            if (player) begin
                x_d = x_board & ~last_q;
            end else begin
                o_d = o_board & ~last_q;
            end
            player_d   = ~player;
            last_vld_d = 1'b0;
            state_d    = IDLE;
        end
`endif
        else begin
            unique case (state)
                IDLE: begin
                    if (bus.idx_valid) begin
                        idx_d   = bus.cell_idx;
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (legal) begin
                        move_d  = onehot;
                        mv_d    = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        reject_d = 1'b1;
                        state_d  = IDLE;
                    end
                end
                ISSUE: begin
                    if (bus.move_ready) begin
                        if (player) begin
                            o_d = o_board | move_q;
                        end else begin
                            x_d = x_board | move_q;
                        end
                        player_d = ~player;
                        move_d   = '0;
                        mv_d     = 1'b0;
`ifdef MOVE_UNDO_EN
                        last_d     = move_q;
                        last_vld_d = 1'b1;
`endif
                        state_d = ((x_d | o_d) == ALL) ? FULL : IDLE;
                    end
                end
                FULL: begin
                    state_d = FULL;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            idx_q   <= '0;
            move_q  <= '0;
            mv_q    <= 1'b0;
            player  <= 1'b0;
            x_board <= '0;
            o_board <= '0;
            reject  <= 1'b0;
`ifdef MOVE_UNDO_EN
            last_q   <= '0;
            last_vld <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            idx_q   <= idx_d;
            move_q  <= move_d;
            mv_q    <= mv_d;
            player  <= player_d;
            x_board <= x_d;
            o_board <= o_d;
            reject  <= reject_d;
`ifdef MOVE_UNDO_EN
            last_q   <= last_d;
            last_vld <= last_vld_d;
`endif
        end
    end

endmodule

// File: tb/tb_move_decoder.sv
// Scoreboard testbench for move_decoder.
// Expected moves are queued at request time and popped on acceptance.
module tb_move_decoder;

    localparam int CELLS = 9;
    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             clear_board;
    logic             player;
    logic [CELLS-1:0] x_board;
    logic [CELLS-1:0] o_board;
    logic             reject;
    logic             board_full;
`ifdef MOVE_UNDO_EN
    logic             undo;
`endif

    move_decoder_if #(.CELLS(CELLS), .IDX_W(IDX_W)) bus ();

    move_decoder #(.CELLS(CELLS), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .clear_board(clear_board),
`ifdef MOVE_UNDO_EN
        .undo       (undo),
`endif
        .player     (player),
        .x_board    (x_board),
        .o_board    (o_board),
        .reject     (reject),
        .board_full (board_full)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [CELLS-1:0] exp_q[$];
    logic [CELLS-1:0] exp_m;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one request; after return the CHECK result is visible.
    task automatic issue_req(input logic [IDX_W-1:0] idx, input bit push);
        logic [CELLS-1:0] oh;
        oh = CELLS'(1) << idx;
        bus.cell_idx  = idx;
        bus.idx_valid = 1'b1;
        if (push) exp_q.push_back(oh);
        step();
        bus.idx_valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        total++;
        if (bus.move_valid !== 1'b0 || bus.move !== '0) begin
            bad++;
            $display("FAIL reset_move got=%b/%h exp=0/000", bus.move_valid, bus.move);
        end
        total++;
        if ({player, reject, board_full} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=000", {player, reject, board_full});
        end
        total++;
        if (x_board !== '0 || o_board !== '0) begin
            bad++;
            $display("FAIL reset_boards got=%h/%h exp=000/000", x_board, o_board);
        end
    endtask

    task automatic test_first_move();
        bus.move_ready = 1'b1;
        bus.cell_idx   = 4'd4;
        bus.idx_valid  = 1'b1;
        exp_q.push_back(9'h010);
        step();
        bus.idx_valid = 1'b0;
        total++;
        if (bus.move_valid !== 1'b0) begin
            bad++;
            $display("FAIL early_valid got=%b exp=0", bus.move_valid);
        end
        step();
        exp_m = exp_q.pop_front();
        total++;
        if (bus.move_valid !== 1'b1 || bus.move !== exp_m) begin
            bad++;
            $display("FAIL first_move got=%b/%h exp=1/%h", bus.move_valid, bus.move, exp_m);
        end
        step();
        total++;
        if (x_board !== 9'h010 || player !== 1'b1 || bus.move_valid !== 1'b0) begin
            bad++;
            $display("FAIL first_commit got=%h/%b/%b exp=010/1/0", x_board, player, bus.move_valid);
        end
    endtask

    task automatic test_reject_occupied();
        issue_req(4'd4, 1'b0);
        total++;
        if (reject !== 1'b1 || bus.move_valid !== 1'b0) begin
            bad++;
            $display("FAIL rej_occ got=%b/%b exp=1/0", reject, bus.move_valid);
        end
        step();
        total++;
        if (reject !== 1'b0 || o_board !== '0 || player !== 1'b1) begin
            bad++;
            $display("FAIL rej_pulse got=%b/%h/%b exp=0/000/1", reject, o_board, player);
        end
    endtask

    task automatic test_reject_range();
        logic [IDX_W-1:0] bad_idx[2];
        bad_idx[0] = 4'd9;
        bad_idx[1] = 4'd15;
        for (int i = 0; i < 2; i++) begin
            issue_req(bad_idx[i], 1'b0);
            total++;
            if (reject !== 1'b1 || bus.move_valid !== 1'b0) begin
                bad++;
                $display("FAIL rej_range[%0d] got=%b/%b exp=1/0", bad_idx[i], reject, bus.move_valid);
            end
            step();
            total++;
            if (x_board !== 9'h010 || o_board !== '0) begin
                bad++;
                $display("FAIL rej_boards[%0d] got=%h/%h exp=010/000", bad_idx[i], x_board, o_board);
            end
        end
    endtask

    task automatic test_hold();
        bus.move_ready = 1'b0;
        issue_req(4'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (bus.move_valid !== 1'b1 || bus.move !== exp_q[0] || o_board !== '0) begin
                bad++;
                $display("FAIL hold[%0d] got=%b/%h/%h exp=1/%h/000", i, bus.move_valid, bus.move, o_board, exp_q[0]);
            end
            step();
        end
        bus.move_ready = 1'b1;
        exp_m = exp_q.pop_front();
        total++;
        if (bus.move !== exp_m) begin
            bad++;
            $display("FAIL hold_accept got=%h exp=%h", bus.move, exp_m);
        end
        step();
        total++;
        if (o_board !== 9'h001 || player !== 1'b0) begin
            bad++;
            $display("FAIL hold_commit got=%h/%b exp=001/0", o_board, player);
        end
    endtask

    task automatic test_back_to_back_fill();
        clear_board = 1'b1;
        step();
        clear_board = 1'b0;
        bus.move_ready = 1'b1;
        for (int i = 0; i < CELLS; i++) begin
            issue_req(IDX_W'(i), 1'b1);
            exp_m = exp_q.pop_front();
            total++;
            if (bus.move_valid !== 1'b1 || bus.move !== exp_m) begin
                bad++;
                $display("FAIL fill[%0d] got=%b/%h exp=1/%h", i, bus.move_valid, bus.move, exp_m);
            end
            step();
        end
        total++;
        if (board_full !== 1'b1 || x_board !== 9'h155 || o_board !== 9'h0AA) begin
            bad++;
            $display("FAIL full got=%b/%h/%h exp=1/155/0aa", board_full, x_board, o_board);
        end
        bus.cell_idx  = 4'd3;
        bus.idx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (reject !== 1'b0 || bus.move_valid !== 1'b0 || board_full !== 1'b1) begin
                bad++;
                $display("FAIL full_ignore[%0d] got=%b/%b/%b exp=0/0/1", i, reject, bus.move_valid, board_full);
            end
        end
        bus.idx_valid = 1'b0;
        clear_board = 1'b1;
        step();
        clear_board = 1'b0;
        total++;
        if (x_board !== '0 || o_board !== '0 || player !== 1'b0 || board_full !== 1'b0) begin
            bad++;
            $display("FAIL full_clear got=%h/%h/%b/%b exp=000/000/0/0", x_board, o_board, player, board_full);
        end
    endtask

    task automatic test_clear_issue();
        bus.move_ready = 1'b0;
        issue_req(4'd8, 1'b1);
        total++;
        if (bus.move_valid !== 1'b1 || bus.move !== exp_q[0]) begin
            bad++;
            $display("FAIL ci_issue got=%b/%h exp=1/%h", bus.move_valid, bus.move, exp_q[0]);
        end
        clear_board = 1'b1;
        step();
        clear_board = 1'b0;
        void'(exp_q.pop_front());
        total++;
        if (bus.move_valid !== 1'b0 || bus.move !== '0 || x_board !== '0 || o_board !== '0) begin
            bad++;
            $display("FAIL ci_drop got=%b/%h/%h/%h exp=0/000/000/000", bus.move_valid, bus.move, x_board, o_board);
        end
        bus.move_ready = 1'b1;
        step();
        total++;
        if (x_board !== '0 || player !== 1'b0) begin
            bad++;
            $display("FAIL ci_late_ready got=%h/%b exp=000/0", x_board, player);
        end
    endtask

`ifdef MOVE_UNDO_EN
    task automatic test_undo();
        bus.move_ready = 1'b1;
        issue_req(4'd2, 1'b1);
        exp_m = exp_q.pop_front();
        total++;
        if (bus.move !== exp_m) begin
            bad++;
            $display("FAIL undo_move got=%h exp=%h", bus.move, exp_m);
        end
        step();
        total++;
        if (x_board !== 9'h004 || player !== 1'b1) begin
            bad++;
            $display("FAIL undo_pre got=%h/%b exp=004/1", x_board, player);
        end
        undo = 1'b1;
        step();
        undo = 1'b0;
        total++;
        if (x_board !== '0 || player !== 1'b0) begin
            bad++;
            $display("FAIL undo got=%h/%b exp=000/0", x_board, player);
        end
        undo = 1'b1;
        step();
        undo = 1'b0;
        total++;
        if (player !== 1'b0 || o_board !== '0) begin
            bad++;
            $display("FAIL undo_twice got=%b/%h exp=0/000", player, o_board);
        end
    endtask
`endif

    initial begin
        reset_n        = 1'b0;
        clear_board    = 1'b0;
        bus.cell_idx   = '0;
        bus.idx_valid  = 1'b0;
        bus.move_ready = 1'b0;
`ifdef MOVE_UNDO_EN
        undo = 1'b0;
`endif
        test_reset();
        test_first_move();
        test_reject_occupied();
        test_reject_range();
        test_hold();
        test_back_to_back_fill();
        test_clear_issue();
`ifdef MOVE_UNDO_EN
        test_undo();
`endif
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
